// File: rtl/img_mem_responder_pkg.sv
// img_mem_pkg: FSM state type and frame geometry helpers shared by img_mem_responder
package img_mem_pkg;
   typedef enum logic [1:0] {LOAD, SERVE, DRAIN} state_t;
   function automatic int calc_depth(input int w, input int h);
      return w * h;
   endfunction
   function automatic int calc_addr_w(input int w, input int h);
      return $clog2(w * h);
   endfunction
endpackage

// File: rtl/img_mem_responder_if.sv
// img_mem_responder_if: load stream (wr_*), read request (addr_*) and read data (dout_*) handshakes
//   slave  : responder side (img_mem_responder)
//   master : pixel source / fetcher side
interface img_mem_responder_if #(parameter int W_DATA = 8, parameter int W_ADDR = 12);
   logic              wr_valid;
   logic              wr_ready;
   logic [W_DATA-1:0] wr_data;
   logic              addr_valid;
   logic              addr_ready;
   logic [W_ADDR-1:0] addr;
   logic              dout_valid;
   logic              dout_ready;
   logic [W_DATA-1:0] dout_data;
   modport slave (
      input  wr_valid, wr_data, addr_valid, addr, dout_ready,
      output wr_ready, addr_ready, dout_valid, dout_data
   );
   modport master (
      output wr_valid, wr_data, addr_valid, addr, dout_ready,
      input  wr_ready, addr_ready, dout_valid, dout_data
   );
endinterface

// File: rtl/img_mem_responder_resp_fifo.sv
// resp_fifo: 2-entry fall-through valid/ready FIFO with occupancy count for credit logic
//   clk, rst (async active-low), i_valid/i_data push (no ready; caller guarantees space),
//   o_valid/o_ready/o_data pop side, o_count stored entries
module resp_fifo #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [2];
   logic [1:0]   r_count;
   logic         w_pop;
   // empty FIFO passes push data straight through so data is visible the cycle it arrives
   assign o_valid = (r_count != 2'd0) || i_valid;
   assign o_data  = (r_count != 2'd0) ? r_mem[0] : (i_valid ? i_data : '0);
   assign o_count = r_count;
   assign w_pop   = o_valid && o_ready;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_count <= 2'd0;
      else      r_count <= r_count + 2'(i_valid) - 2'(w_pop);
   end
   always_ff @(posedge clk) begin
      r_mem[0] <= w_pop ? ((r_count == 2'd2) ? r_mem[1] : i_data) : ((r_count == 2'd0) ? i_data : r_mem[0]);
      r_mem[1] <= ((r_count == 2'd1 && !w_pop) || (r_count == 2'd2 && w_pop)) ? i_data : r_mem[1];
   end
endmodule

// File: rtl/img_mem_responder.sv
// img_mem_responder: single-frame pixel RAM loaded from a row-major stream and served to data_fetcher
//   clk, rst (async active-low), bus (img_mem_responder_if.slave: wr_*, addr_*, dout_*),
//   frame_release (pulse: frame done), loaded (frame resident), range_err (sticky out-of-range flag)
//   Optional build macro IMG_MEM_RANGE_CHECK_EN: out-of-range reads return 0 and set range_err.
module img_mem_responder import img_mem_pkg::*; #(
   parameter int W_DATA     = 8,
   parameter int IMG_WIDTH  = 41,
   parameter int IMG_HEIGHT = 50
) (
   input  logic                clk,
   input  logic                rst,
   img_mem_responder_if.slave  bus,
   input  logic                frame_release,
   output logic                loaded,
   output logic                range_err
);
   localparam int DEPTH  = calc_depth(IMG_WIDTH, IMG_HEIGHT);
   localparam int W_ADDR = calc_addr_w(IMG_WIDTH, IMG_HEIGHT);
   state_t            r_state, w_next;
   logic [W_ADDR-1:0] r_wr_ptr;
   logic [W_DATA-1:0] r_mem [DEPTH];
   logic [W_DATA-1:0] r_rd_data;
   logic              r_inflight;
   logic [1:0]        w_count;
   logic              w_wr_hs, w_addr_hs, w_last, w_oor;
   assign w_wr_hs   = bus.wr_valid && bus.wr_ready;
   assign w_addr_hs = bus.addr_valid && bus.addr_ready;
   assign w_last    = r_wr_ptr == W_ADDR'(DEPTH - 1);
   assign loaded    = r_state != LOAD;
   always_comb begin
      w_next         = r_state;
      bus.wr_ready   = 1'b0;
      bus.addr_ready = 1'b0;
      case (r_state)
         LOAD: begin
            bus.wr_ready = 1'b1;
            if (bus.wr_valid && w_last) w_next = SERVE;
         end
         SERVE: begin
            // credits: the RAM read in flight plus stored entries never exceed FIFO capacity
            bus.addr_ready = (2'(r_inflight) + w_count) < 2'd2;
            if (frame_release) w_next = DRAIN;
         end
         DRAIN: if (!r_inflight && w_count == 2'd0) w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LOAD;
         r_wr_ptr   <= '0;
         r_inflight <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_addr_hs;
         if (w_wr_hs) r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
         if (w_addr_hs) r_rd_data <= w_oor ? '0 : r_mem[bus.addr];
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr_hs) r_mem[r_wr_ptr] <= bus.wr_data;
   end
`ifdef IMG_MEM_RANGE_CHECK_EN
   logic r_range_err;
   assign w_oor     = {1'b0, bus.addr} >= (W_ADDR + 1)'(DEPTH);
   assign range_err = r_range_err;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_range_err <= 1'b0;
      else      r_range_err <= r_range_err || (w_addr_hs && w_oor);
   end
`else
   assign w_oor     = 1'b0;
   assign range_err = 1'b0;
`endif
   resp_fifo #(.W(W_DATA)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_inflight),
      .i_data  (r_rd_data),
      .o_valid (bus.dout_valid),
      .o_ready (bus.dout_ready),
      .o_data  (bus.dout_data),
      .o_count (w_count)
   );
endmodule

// File: doc/img_mem_responder.md
Name: img_mem_responder

Overview:
- Responder end of the fetcher's address/data protocol. Accepts pixel addresses on `addr_*` and returns pixel data on `dout_*`, which feed the fetcher's `din_*` port.
- Holds one frame in an internal single-port-per-side synchronous RAM.
- The frame is loaded from a row-major pixel stream. It is then served until the classifier releases it.
- Sits between the camera/DMA pixel source and `data_fetcher`.

Parameters:
- W_DATA, 8, pixel width.
- IMG_WIDTH, 41, frame width in pixels.
- IMG_HEIGHT, 50, frame height in pixels.
- DEPTH (localparam), IMG_WIDTH*IMG_HEIGHT, memory words (2050 at defaults).
- W_ADDR (localparam), $clog2(DEPTH), address width (12 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_valid  in  1  load-stream pixel valid.
- wr_ready  out  1  load-stream ready.
- wr_data  in  W_DATA  pixel, row-major order starting at address 0.
- frame_release  in  1  single-cycle pulse: current frame no longer needed.
- loaded  out  1  frame resident and being served (state SERVE).
- addr_valid  in  1  read request valid.
- addr_ready  out  1  read request accepted.
- addr  in  W_ADDR  pixel address, y*IMG_WIDTH+x.
- dout_valid  out  1  read data valid.
- dout_ready  in  1  read data accepted.
- dout_data  out  W_DATA  read data.
- range_err  out  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset values (rst=0, asynchronous):
  - state LOAD, wr_ptr=0, in-flight=0, FIFO empty.
  - wr_ready=1 after rst deasserts; loaded=0, addr_ready=0, dout_valid=0, dout_data=0, range_err=0.
  - RAM contents are not cleared.
  - A reset mid-operation discards all in-flight reads and buffered data.
- States: LOAD, SERVE, DRAIN.
- LOAD:
  - wr_ready=1, addr_ready=0.
  - Each wr handshake writes RAM[wr_ptr] and increments wr_ptr.
  - A handshake with wr_ptr==DEPTH-1 sets wr_ptr=0 and moves to SERVE; loaded=1 the following cycle.
  - frame_release is ignored in LOAD.
- SERVE:
  - wr_ready=0.
  - addr_ready=1 iff (inflight + fifo_count) < 2. This is registered/credit-based, with no combinational path from dout_ready.
  - On an addr handshake in cycle N, the RAM is read, the data is pushed into the 2-entry output FIFO at the end of cycle N+1, and dout_valid=1 from cycle N+1.
  - Minimum latency is 1 cycle. Throughput is 1 read/cycle while dout_ready=1.
  - Responses are returned strictly in request order.
  - frame_release moves to DRAIN. An addr handshake in the same cycle is still accepted and served.
- DRAIN:
  - addr_ready=0; loaded stays 1.
  - Pending in-flight and FIFO data are delivered normally.
  - When in-flight=0, the FIFO is empty and no pop is outstanding, move to LOAD; loaded=0 and wr_ready=1 the next cycle.
- dout_valid/dout_data hold stable while dout_valid & !dout_ready (AXI-style rule: valid is never withdrawn).
- FIFO:
  - A simultaneous push and pop when full is not possible because credits prevent it.
  - A simultaneous push and pop when count=1 keeps count=1.

Optional Feature:
- Macro IMG_MEM_RANGE_CHECK_EN.
- Defined: an accepted addr ≥ DEPTH does not read the RAM. The response returns dout_data=0 with normal latency and ordering. range_err sets the cycle after acceptance and stays 1 until reset.
- Undefined: no compare logic; range_err is tied 0. Data for addr ≥ DEPTH is whatever the RAM returns, but the handshake still completes (no hang).

Decomposition:
- Package img_mem_pkg: state enum (LOAD/SERVE/DRAIN) and a function computing DEPTH and W_ADDR from width/height.
- One sub-module: resp_fifo, a 2-entry valid/ready FIFO with a count output used for credit computation.
- The RAM is an inferred array in the top module.

Test Plan:
- Load ramp wr_data=i mod 256 for i=0..2049 with wr_valid=1 -> wr_ready=1 throughout, then loaded=1 and wr_ready=0 the cycle after the last handshake.
- After load, addrs 0,1,2049 back-to-back with dout_ready=1 -> dout_data 0,1,1 on consecutive cycles starting 1 cycle after the first handshake.
- dout_ready=0 with addr_valid=1 -> exactly 2 addrs accepted, then addr_ready=0. After dout_ready=1, data returns in order and addr_ready reasserts.
- frame_release with 2 responses pending -> addr_ready=0, both responses delivered, then loaded=0 and wr_ready=1. A second frame loads correctly.
- rst pulled low while dout_valid=1 -> dout_valid=0, loaded=0, range_err=0 immediately. wr_ready=1 after release; previous RAM data remains readable only after a full reload.
- With IMG_MEM_RANGE_CHECK_EN, addr=2050 -> dout_data=0, range_err=1 and sticky; a following addr=5 returns the pixel 5 value normally.
